// File: rtl/write_nonsym_checker.sv
// Receive-side checker for the nonsymmetric pipe benchmark.
// The host streams 32-bit pipe words. Each pair of words is rebuilt into one 64-bit word:
// the first word is the low half and the second is the high half. Every 64-bit word is
// compared with a locally generated reference sequence. The block counts words, mismatches
// and the clock cycles spent in the transfer.
//
// Ports:
//   clk               okClk; all logic runs on the rising edge
//   reset_n           asynchronous active-low reset
//   pattern           [1:0] pattern mode, [31:2] seed (mode is sampled on start)
//   reset_pattern     synchronous clear; overrides every other input
//   start / stop      trigger pulses that begin and end a transfer
//   transfer_len      number of 64-bit words before finishing on its own; 0 = unlimited
//   pipe_in_write     okPipeIn write strobe
//   pipe_in_data      okPipeIn data word
//   clk_counts        cycles spent running
//   word_count        64-bit words checked
//   error_count       mismatching words (saturating)
//   first_error_index word_count value of the first mismatch; all-ones if there was none
//   running / done    FSM status
module write_nonsym_checker #(
  parameter int unsigned CNT_W = 64,
  parameter int unsigned ERR_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      pattern,
  input  logic             reset_pattern,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      transfer_len,
  input  logic             pipe_in_write,
  input  logic [31:0]      pipe_in_data,
  output logic [CNT_W-1:0] clk_counts,
  output logic [ERR_W-1:0] word_count,
  output logic [ERR_W-1:0] error_count,
  output logic [ERR_W-1:0] first_error_index,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRunLo, StRunHi, StDone} state_e;

  state_e      state;
  logic [1:0]  mode;
  logic [63:0] gen_word;
  logic [31:0] low_half;

  // First reference word of a transfer for a given mode and seed.
  function automatic logic [63:0] gen_first(input logic [1:0] m, input logic [29:0] s);
    logic [63:0] w;
    case (m)
      2'd0:    w = {s, 2'b00, s, 2'b00};
      2'd1:    w = {32'd0, s, 2'b00};
      2'd2:    w = 64'd1;
      default: w = {32'hFFFF_FFFF, s, 2'b01};
    endcase
    return w;
  endfunction

  // Reference word that follows w in the given mode.
  function automatic logic [63:0] gen_next(input logic [1:0] m, input logic [63:0] w);
    logic [63:0] n;
    case (m)
      2'd0:    n = w;
      2'd1:    n = w + 64'd1;
      2'd2:    n = {w[62:0], w[63]};
      // Fibonacci LFSR with taps 64, 63, 61 and 60.
      default: n = {w[62:0], w[63] ^ w[62] ^ w[60] ^ w[59]};
    endcase
    return n;
  endfunction

  logic [63:0]      rx_word;
  logic             word_bad;
  logic [ERR_W-1:0] wc_inc;
  logic             last_word;

  assign rx_word   = {pipe_in_data, low_half};
  assign word_bad  = (rx_word != gen_word);
  assign wc_inc    = word_count + ERR_W'(1);
  assign last_word = (transfer_len != 32'd0) && (wc_inc == ERR_W'(transfer_len));

  // The generator is loaded from the pattern word on start; its reset value is never compared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= StIdle;
      mode              <= 2'd0;
      gen_word          <= '0;
      low_half          <= '0;
      clk_counts        <= '0;
      word_count        <= '0;
      error_count       <= '0;
      first_error_index <= '1;
      running           <= 1'b0;
      done              <= 1'b0;
    end else if (reset_pattern) begin
      state             <= StIdle;
      mode              <= 2'd0;
      gen_word          <= '0;
      low_half          <= '0;
      clk_counts        <= '0;
      word_count        <= '0;
      error_count       <= '0;
      first_error_index <= '1;
      running           <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (state)
        StIdle, StDone: begin
          // When start and stop arrive together, stop wins and the state is held.
          if (start && !stop) begin
            state             <= StRunLo;
            running           <= 1'b1;
            done              <= 1'b0;
            mode              <= pattern[1:0];
            gen_word          <= gen_first(pattern[1:0], pattern[31:2]);
            low_half          <= '0;
            clk_counts        <= CNT_W'(1);
            word_count        <= '0;
            error_count       <= '0;
            first_error_index <= '1;
          end
        end
        StRunLo: begin
          clk_counts <= clk_counts + CNT_W'(1);
          if (stop) begin
            state   <= StDone;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (pipe_in_write) begin
            low_half <= pipe_in_data;
            state    <= StRunHi;
          end
        end
        StRunHi: begin
          clk_counts <= clk_counts + CNT_W'(1);
          if (pipe_in_write) begin
            // A completing strobe is always checked, even when stop arrives in the same cycle.
            word_count <= wc_inc;
            gen_word   <= gen_next(mode, gen_word);
            if (word_bad) begin
              if (error_count != '1) error_count <= error_count + ERR_W'(1);
              if (first_error_index == '1) first_error_index <= word_count;
            end
            if (stop || last_word) begin
              state   <= StDone;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= StRunLo;
            end
          end else if (stop) begin
            // Any pending low half is dropped.
            state   <= StDone;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/write_nonsym_checker.md
Name: write_nonsym_checker

Overview:
- Receiving end of the nonsymmetric pipe benchmark: host streams 32-bit words over okPipeIn, block reassembles 64-bit words and checks each against an internally generated reference pattern.
- Counts words, errors and okClk cycles of the transfer; results are exposed to okWireOut endpoints.
- Sits between okPipeIn (ep 0x80) and the wire-out bank in the write-direction top level.

Parameters:
- CNT_W, 64, width of cycle counter.
- ERR_W, 32, width of error counter and first-error index.

Ports:
- clk  input  1  okClk; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pattern  input  32  okWireIn 0x01. [1:0] = mode, [31:2] = seed.
- reset_pattern  input  1  synchronous pulse; re-arms generator and checker.
- start  input  1  trigger pulse; starts timer and checking.
- stop  input  1  trigger pulse; forces stop.
- transfer_len  input  32  expected number of 64-bit words; 0 = unlimited.
- pipe_in_write  input  1  okPipeIn ep_write strobe.
- pipe_in_data  input  32  okPipeIn ep_dataout.
- clk_counts  output  CNT_W  cycles while running.
- word_count  output  ERR_W  64-bit words checked.
- error_count  output  ERR_W  mismatching 64-bit words.
- first_error_index  output  ERR_W  word_count value of first mismatch; all-ones if none.
- running  output  1  high in RUN state.
- done  output  1  high in DONE state.

Behaviour:
- Reset (reset_n low, async): state IDLE, all counters 0, first_error_index all-ones, running 0, done 0, half-word register 0, generator at seed.
- reset_pattern (sync) has the same effect as reset, except it works at a clock edge; it overrides every other input that cycle.
- Reference generator, 64-bit, advances once per checked word:
  - mode 0: constant {seed,2'b00} in both halves.
  - mode 1: 64-bit counter starting at {32'd0,seed,2'b00}, +1 per word, wraps modulo 2^64.
  - mode 2: walking one starting at bit 0, rotate left 1 per word, bit 63 wraps to bit 0.
  - mode 3: 64-bit Fibonacci LFSR, taps 64,63,61,60, init {32'hFFFFFFFF,seed,2'b01} (never zero).
  - mode is sampled at start; changes to pattern during RUN are ignored.
- Word order: the first pipe word of a pair is bits [31:0], the second is bits [63:32] (matches the read-direction FIFO ordering).
- FSM:
  - IDLE: start -> RUN_LO (clk_counts starts counting that cycle).
  - RUN_LO: on pipe_in_write, latch low half -> RUN_HI.
  - RUN_HI: on pipe_in_write, compare {data,low} with reference -> RUN_LO, or DONE if word_count+1 == transfer_len (transfer_len != 0).
  - stop in any RUN state -> DONE. A pending low half is discarded and not counted.
  - DONE: holds results; start -> RUN_LO, clearing all counters first.
  - pipe_in_write in IDLE/DONE: ignored.
- Compare: registered result, 1-cycle latency after the second strobe. word_count increments every compare; on mismatch error_count increments (saturates at all-ones). first_error_index is loaded only while it is all-ones.
- clk_counts increments every cycle in RUN_LO/RUN_HI, including the cycle start is seen; frozen in DONE.
- If stop and a completing strobe arrive in the same cycle, the word is still checked, then DONE.
- If start and stop arrive in the same cycle, stop wins: IDLE stays IDLE, DONE stays DONE.
- Back-to-back strobes every cycle must be sustained with no loss.

Test Plan:
- Reset, mode 1, seed 0, transfer_len 4: start, send 8 words 0,0,1,0,2,0,3,0 -> word_count 4, error_count 0, first_error_index 0xFFFFFFFF, done 1, running 0.
- Mode 2, transfer_len 3: send pairs (1,0),(2,0),(0,1) -> word 2 mismatches (expected 4) -> error_count 1, first_error_index 2.
- Mode 1, transfer_len 0: send 3 words then stop -> DONE, word_count 1, pending half discarded; clk_counts equals cycles from start to stop inclusive.
- Mode 3, 1000 consecutive strobes every cycle from golden LFSR model -> error_count 0, word_count 500.
- reset_n asserted mid-RUN_HI -> all outputs return to reset values immediately; start after release restarts cleanly.
- start and stop in the same cycle from IDLE -> stays IDLE, clk_counts 0; stop coincident with final strobe -> word checked, word_count incremented, done 1.
